cpu_ctrl_fsm: RTL
=================

# cpu_ctrl_fsm

Multi-cycle control unit for the 16-bit CPU. It sequences fetch, decode, execute, memory and write-back, consuming the one-hot instruction strobes from `instr_decoder` plus the ALU flags, and emits every datapath enable and mux select. It sits between `instr_decoder` and the register file, ALU, PC and memory port, and is the only block that advances the PC or raises `halted`.

## Interface
- `OP_W`, default 25: width of the one-hot decoded-op vector; bit order is fixed in the shared package.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `dec_op`  in  OP_W  one-hot decoder strobes (BCC..HLT).
- `flag_c`, `flag_z`  in  1 each  registered ALU carry and zero flags.
- `mem_ready`  in  1  memory accepts or returns data this cycle.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  write qualifier for `mem_req`.
- `mem_addr_sel`  out  1  memory address select: 0 = PC, 1 = ALU result.
- `ir_we`  out  1  instruction-register load.
- `pc_we`  out  1  PC load.
- `pc_sel`  out  2  next-PC select: 00 = PC+1, 01 = PC+disp, 10 = imm, 11 = Rs.
- `rf_we`  out  1  register-file write.
- `wb_sel`  out  2  write-back source: 00 = ALU, 01 = MEM, 10 = PC+1 (link), 11 = IMM (LLI/LHI).
- `alu_op`  out  3  ALU operation: 000 ADD, 001 ADC, 010 SUB, 011 SBB, 100 PASS_B.
- `flags_we`  out  1  flag register update.
- `out_we`  out  1  OUTR port strobe.
- `halted`  out  1  core is stopped.
- `illegal`  out  1  sticky flag: a non-one-hot `dec_op` was decoded.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH
  - Drives `mem_req`=1 and `mem_addr_sel`=0, held until `mem_ready`.
  - In the `mem_ready` cycle: `ir_we`=1, then go to DECODE.
- DECODE
  - One idle cycle so the decoder can settle from the new IR.
  - Checks that `dec_op` is one-hot. If it is zero or has multiple bits set: set `illegal`, go to HALT.
  - Load/store ops go to MEM; HLT goes to HALT; everything else goes to EXEC.
- EXEC (one cycle), then FETCH. `pc_we`=1 for every op; `pc_sel`=PC+1 unless stated otherwise.
  - ADD/ADC/SUB/SBB/ADDI/SUBI: `rf_we`=1, `flags_we`=1, `alu_op` per op (ADDI→ADD, SUBI→SUB).
  - CMP: `alu_op`=SUB, `flags_we`=1, `rf_we`=0.
  - MOV: `alu_op`=PASS_B, `rf_we`=1.
  - LLI/LHI: `rf_we`=1, `wb_sel`=IMM.
  - Branches: `pc_sel`=01 if taken, else 00.
    - BEQ taken when Z=1; BNE when Z=0; BCS when C=1; BCC when C=0; BAL always.
  - JMP: `pc_sel`=10.
  - JALI: `pc_sel`=10, `rf_we`=1, `wb_sel`=10.
  - JAL: `pc_sel`=11, `rf_we`=1, `wb_sel`=10.
  - JR: `pc_sel`=11.
  - OUTR: `out_we`=1.
- MEM
  - Drives `mem_req`=1, `mem_addr_sel`=1, `alu_op`=ADD, held until `mem_ready`.
  - STR/STRI: `mem_we`=1. In the `mem_ready` cycle, `pc_we`=1 with PC+1, then go to FETCH.
  - LDR/LDRI: `mem_we`=0. In the `mem_ready` cycle, go to WB.
- WB: `rf_we`=1, `wb_sel`=MEM, `pc_we`=1 with PC+1, then go to FETCH.
- HALT: absorbing; `halted`=1. Only reset leaves it.
- `mem_ready` is ignored outside FETCH and MEM.
- All strobes (`ir_we`, `pc_we`, `rf_we`, `flags_we`, `out_we`, `mem_req`) are 0 in any state not listed above.

## Timing
- Reset (async, `rst_n`=0):
  - State becomes FETCH.
  - Every output is 0, including `illegal` and `halted`.
  - Any in-flight `mem_req` drops in the same instant.
- First `mem_req` appears in the first cycle after `rst_n` rises.
- Latency with zero-wait memory:
  - ALU, branch, jump, OUTR: 3 cycles (FETCH, DECODE, EXEC).
  - Store: 3 cycles (FETCH, DECODE, MEM).
  - Load: 4 cycles (FETCH, DECODE, MEM, WB).
- Each wait cycle on `mem_ready` adds one cycle. Outputs hold stable while waiting.
- All outputs are Moore/Mealy on the registered state plus the current `dec_op`, `flag_c`, `flag_z` and `mem_ready`. Flags are sampled in EXEC only.
- Flag write and branch ordering:
  - `flags_we` in cycle N takes effect at the N+1 edge.
  - A branch directly after CMP sees the updated flags, because DECODE separates them.

## Structure
- Shared package `cpu_pkg` holds:
  - the state enum;
  - `dec_op` bit-index localparams (ordered BCC, BCS, BNE, BEQ, BAL, ADD, ADC, SUB, SBB, SUBI, MOV, STRI, STR, CMP, ADDI, LDR, LDRI, LLI, LHI, JMP, JALI, JAL, JR, OUTR, HLT);
  - the `pc_sel`, `wb_sel` and `alu_op` codes.
- One sub-module: `cpu_branch_cond`, combinational, taking `dec_op`, C and Z and producing `taken`.

## Test plan
- Reset check:
  - Stimulus: reset released; one ADD fetched with `mem_ready`=1.
  - Required: `ir_we` at cycle 1, `rf_we`=`flags_we`=`pc_we`=1 with `alu_op`=000 at cycle 3, back in FETCH at cycle 4.
- CMP then branches:
  - Stimulus: CMP, then BEQ with Z=1, then BNE with Z=1.
  - Required: CMP gives `flags_we`=1 and `rf_we`=0; BEQ gives `pc_sel`=01; BNE gives `pc_sel`=00.
- Loads and stores under wait states:
  - Stimulus: LDR with `mem_ready` held low 2 cycles in MEM.
  - Required: `mem_req`, `mem_addr_sel`=1 and `mem_we`=0 stable for 3 cycles; WB shows `wb_sel`=01 and `rf_we`=1; total 6 cycles.
  - Stimulus: STR with `mem_ready`=1.
  - Required: `mem_we`=1 and `pc_we`=1 in the same cycle; total 3 cycles.
- Jumps and links:
  - JALI: `rf_we`=1, `wb_sel`=10, `pc_sel`=10.
  - JAL: `pc_sel`=11 with link.
  - JR: `pc_sel`=11 with `rf_we`=0.
- Halt paths:
  - OUTR: `out_we` pulses exactly one cycle.
  - HLT: `halted`=1 and no further `mem_req` for 20 cycles.
  - `dec_op`=0 in DECODE: `illegal`=1 and `halted`=1.
- Reset mid-operation:
  - Stimulus: drop `rst_n` during MEM with `mem_req` high.
  - Required: `mem_req` falls without waiting for a clock edge; restart fetch on the first edge after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU control path: FSM states,
// decoded-op bit positions and datapath select codes.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam int OP_COUNT = 25;

  localparam int OP_BCC  = 0;
  localparam int OP_BCS  = 1;
  localparam int OP_BNE  = 2;
  localparam int OP_BEQ  = 3;
  localparam int OP_BAL  = 4;
  localparam int OP_ADD  = 5;
  localparam int OP_ADC  = 6;
  localparam int OP_SUB  = 7;
  localparam int OP_SBB  = 8;
  localparam int OP_SUBI = 9;
  localparam int OP_MOV  = 10;
  localparam int OP_STRI = 11;
  localparam int OP_STR  = 12;
  localparam int OP_CMP  = 13;
  localparam int OP_ADDI = 14;
  localparam int OP_LDR  = 15;
  localparam int OP_LDRI = 16;
  localparam int OP_LLI  = 17;
  localparam int OP_LHI  = 18;
  localparam int OP_JMP  = 19;
  localparam int OP_JALI = 20;
  localparam int OP_JAL  = 21;
  localparam int OP_JR   = 22;
  localparam int OP_OUTR = 23;
  localparam int OP_HLT  = 24;

  localparam logic [1:0] PC_SEL_INC  = 2'b00;
  localparam logic [1:0] PC_SEL_DISP = 2'b01;
  localparam logic [1:0] PC_SEL_IMM  = 2'b10;
  localparam logic [1:0] PC_SEL_RS   = 2'b11;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_MEM  = 2'b01;
  localparam logic [1:0] WB_SEL_LINK = 2'b10;
  localparam logic [1:0] WB_SEL_IMM  = 2'b11;

  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_ADC    = 3'b001;
  localparam logic [2:0] ALU_SUB    = 3'b010;
  localparam logic [2:0] ALU_SBB    = 3'b011;
  localparam logic [2:0] ALU_PASS_B = 3'b100;

endpackage

// File: rtl/cpu_branch_cond.sv
// Branch-taken evaluation: each conditional branch strobe is paired with the
// flag condition that makes it taken, and the pairs are OR-reduced.
module cpu_branch_cond
  import cpu_pkg::*;
#(
  parameter int OP_W = OP_COUNT
) (
  input  logic [OP_W-1:0] i_dec_op,
  input  logic            i_flag_c,
  input  logic            i_flag_z,
  output logic            o_taken
);

  logic [OP_W-1:0] w_cond;

  always_comb begin
    w_cond         = '0;
    w_cond[OP_BCC] = ~i_flag_c;
    w_cond[OP_BCS] = i_flag_c;
    w_cond[OP_BNE] = ~i_flag_z;
    w_cond[OP_BEQ] = i_flag_z;
    w_cond[OP_BAL] = 1'b1;
  end

  assign o_taken = |(i_dec_op & w_cond);

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB/HALT and
// drives every datapath enable and select from the registered state.
module cpu_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int OP_W = OP_COUNT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] dec_op,
  input  logic            flag_c,
  input  logic            flag_z,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            mem_we,
  output logic            mem_addr_sel,
  output logic            ir_we,
  output logic            pc_we,
  output logic [1:0]      pc_sel,
  output logic            rf_we,
  output logic [1:0]      wb_sel,
  output logic [2:0]      alu_op,
  output logic            flags_we,
  output logic            out_we,
  output logic            halted,
  output logic            illegal,
  output logic [2:0]      o_dbg_state
);

  state_e r_state;
  logic   r_started;
  logic   r_illegal;
  logic   w_taken;
  logic   w_onehot;
  logic   w_is_store;
  logic   w_is_load;
  logic   w_is_branch;

  cpu_branch_cond #(.OP_W(OP_W)) u_branch_cond (
    .i_dec_op (dec_op),
    .i_flag_c (flag_c),
    .i_flag_z (flag_z),
    .o_taken  (w_taken)
  );

  assign w_onehot    = (dec_op != '0) &&
                       ((dec_op & (dec_op - {{(OP_W-1){1'b0}}, 1'b1})) == '0);
  assign w_is_store  = dec_op[OP_STR] | dec_op[OP_STRI];
  assign w_is_load   = dec_op[OP_LDR] | dec_op[OP_LDRI];
  assign w_is_branch = dec_op[OP_BCC] | dec_op[OP_BCS] | dec_op[OP_BNE] |
                       dec_op[OP_BEQ] | dec_op[OP_BAL];

  // r_started keeps outputs quiet until the first edge after reset release,
  // so the first fetch request appears one cycle after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_FETCH;
      r_started <= 1'b0;
      r_illegal <= 1'b0;
    end else if (!r_started) begin
      r_started <= 1'b1;
    end else begin
      case (r_state)
        ST_FETCH:  if (mem_ready) r_state <= ST_DECODE;
        ST_DECODE: begin
          if (!w_onehot) begin
            r_illegal <= 1'b1;
            r_state   <= ST_HALT;
          end else if (w_is_store || w_is_load) begin
            r_state <= ST_MEM;
          end else if (dec_op[OP_HLT]) begin
            r_state <= ST_HALT;
          end else begin
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC:   r_state <= ST_FETCH;
        ST_MEM:    if (mem_ready) r_state <= w_is_store ? ST_FETCH : ST_WB;
        ST_WB:     r_state <= ST_FETCH;
        ST_HALT:   r_state <= ST_HALT;
        default:   r_state <= ST_FETCH;
      endcase
    end
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_SEL_INC;
    rf_we        = 1'b0;
    wb_sel       = WB_SEL_ALU;
    alu_op       = ALU_ADD;
    flags_we     = 1'b0;
    out_we       = 1'b0;
    if (r_started) begin
      case (r_state)
        ST_FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
        end
        ST_EXEC: begin
          pc_we = 1'b1;
          if (dec_op[OP_ADD] || dec_op[OP_ADDI]) alu_op = ALU_ADD;
          if (dec_op[OP_ADC])                    alu_op = ALU_ADC;
          if (dec_op[OP_SUB] || dec_op[OP_SUBI] || dec_op[OP_CMP]) alu_op = ALU_SUB;
          if (dec_op[OP_SBB])                    alu_op = ALU_SBB;
          if (dec_op[OP_MOV])                    alu_op = ALU_PASS_B;
          flags_we = dec_op[OP_ADD] | dec_op[OP_ADC] | dec_op[OP_SUB] |
                     dec_op[OP_SBB] | dec_op[OP_ADDI] | dec_op[OP_SUBI] |
                     dec_op[OP_CMP];
          rf_we    = dec_op[OP_ADD] | dec_op[OP_ADC] | dec_op[OP_SUB] |
                     dec_op[OP_SBB] | dec_op[OP_ADDI] | dec_op[OP_SUBI] |
                     dec_op[OP_MOV] | dec_op[OP_LLI] | dec_op[OP_LHI] |
                     dec_op[OP_JALI] | dec_op[OP_JAL];
          if (dec_op[OP_LLI] || dec_op[OP_LHI])  wb_sel = WB_SEL_IMM;
          if (dec_op[OP_JALI] || dec_op[OP_JAL]) wb_sel = WB_SEL_LINK;
          if (w_is_branch && w_taken)            pc_sel = PC_SEL_DISP;
          if (dec_op[OP_JMP] || dec_op[OP_JALI]) pc_sel = PC_SEL_IMM;
          if (dec_op[OP_JAL] || dec_op[OP_JR])   pc_sel = PC_SEL_RS;
          out_we = dec_op[OP_OUTR];
        end
        ST_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          alu_op       = ALU_ADD;
          mem_we       = w_is_store;
          pc_we        = w_is_store & mem_ready;
        end
        ST_WB: begin
          rf_we  = 1'b1;
          wb_sel = WB_SEL_MEM;
          pc_we  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign halted      = r_started & (r_state == ST_HALT);
  assign illegal     = r_illegal;
  assign o_dbg_state = r_state;

endmodule
